// File: rtl/mem_stage_lsu.sv
// Memory pipeline stage: holds one execute result, waits for in-order load
// responses, extracts/extends load data and hands the result to writeback.
module mem_stage_lsu #(
  parameter int DATA_W    = 32,
  parameter int DISCARD_W = 2,
  parameter int ES_WD     = DATA_W + 42,
  parameter int WS_WD     = DATA_W + 38
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ws_allowin,
  output logic              ms_allowin,
  input  logic              es_to_ms_valid,
  input  logic [ES_WD-1:0]  es_to_ms_bus,
  output logic              ms_to_ws_valid,
  output logic [WS_WD-1:0]  ms_to_ws_bus,
  input  logic              ms_flush,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              ms_fwd_valid,
  output logic [4:0]        ms_fwd_dest,
  output logic              ms_fwd_ready,
  output logic [DATA_W-1:0] ms_fwd_data
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_FULL} state_t;

  typedef struct packed {
    logic [2:0]        mem_op;
    logic              res_from_mem;
    logic              gr_we;
    logic [4:0]        dest;
    logic [DATA_W-1:0] alu_result;
    logic [31:0]       pc;
  } entry_t;

  state_t               state_q, state_d;
  entry_t               entry_q, es_entry;
  logic [DATA_W-1:0]    rbuf_q;
  logic [DISCARD_W-1:0] discard_cnt;

  logic usable, ready_go, accept, disc_inc, disc_dec;

  assign es_entry = entry_t'(es_to_ms_bus);

  // A response is ours only once every stale (flushed) response has drained.
  assign usable     = data_data_ok && (discard_cnt == '0) && (state_q == S_WAIT);
  assign ready_go   = (state_q == S_FULL) || usable;
  assign ms_allowin = (state_q == S_EMPTY) || (ready_go && ws_allowin);
  assign accept     = es_to_ms_valid && ms_allowin && !ms_flush;
  assign ms_to_ws_valid = ready_go && !ms_flush;

  assign disc_inc = ms_flush && (state_q == S_WAIT) && !usable;
  assign disc_dec = data_data_ok && (discard_cnt != '0);

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (ms_flush)        state_d = S_EMPTY;
    else if (accept)     state_d = es_entry.res_from_mem ? S_WAIT : S_FULL;
    else if (ms_allowin) state_d = S_EMPTY;
    else if (usable)     state_d = S_FULL;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  // NOTE: the payload and rbuf are reset too, so the output bus reads zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q <= '0;
      rbuf_q  <= '0;
    end else begin
      if (accept) entry_q <= es_entry;
      if (usable && !ws_allowin && !ms_flush) rbuf_q <= data_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) discard_cnt <= '0;
    else begin
      case ({disc_inc, disc_dec})
        2'b10:   discard_cnt <= discard_cnt + 1'b1;
        2'b01:   discard_cnt <= discard_cnt - 1'b1;
        default: discard_cnt <= discard_cnt;
      endcase
    end
  end

  a_no_discard_overflow: assert property (@(posedge clk) disable iff (reset)
    !(disc_inc && !disc_dec && (&discard_cnt)));

  // Load data comes from rbuf once captured, otherwise straight off the bus.
  logic [DATA_W-1:0] load_data, extracted, final_result;
  logic [OFF_W-1:0]  off;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       word_v;

  assign load_data = (state_q == S_FULL) ? rbuf_q : data_rdata;
  assign off       = entry_q.alu_result[OFF_W-1:0];
  assign byte_v    = load_data[{off, 3'b000} +: 8];
  assign half_v    = load_data[{off[OFF_W-1:1], 4'b0000} +: 16];

  generate
    if (DATA_W == 64) begin : g_word64
      assign word_v = load_data[{off[OFF_W-1], 5'b00000} +: 32];
    end else begin : g_word32
      assign word_v = load_data[31:0];
    end
  endgenerate

  always_comb begin
    extracted = DATA_W'(signed'(word_v));
    case (entry_q.mem_op)
      3'd1:    extracted = DATA_W'(signed'(byte_v));
      3'd2:    extracted = DATA_W'(signed'(half_v));
      3'd3:    extracted = DATA_W'(byte_v);
      3'd4:    extracted = DATA_W'(half_v);
      3'd5:    extracted = (DATA_W == 64) ? load_data : DATA_W'(signed'(word_v));
      default: extracted = DATA_W'(signed'(word_v));
    endcase
  end

  assign final_result = entry_q.res_from_mem ? extracted : entry_q.alu_result;
  assign ms_to_ws_bus = {entry_q.gr_we, entry_q.dest, final_result, entry_q.pc};

  assign ms_fwd_valid = (state_q != S_EMPTY) && entry_q.gr_we;
  assign ms_fwd_dest  = entry_q.dest;
  assign ms_fwd_ready = ready_go;
  assign ms_fwd_data  = final_result;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed literal cases plus a randomized run
// checked every cycle against an occupancy/queue-level reference model.
module tb_mem_stage_lsu;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        ws_allowin, ms_allowin, es_to_ms_valid, ms_to_ws_valid;
  logic [73:0] es_to_ms_bus;
  logic [69:0] ms_to_ws_bus;
  logic        ms_flush, data_data_ok, ms_fwd_valid, ms_fwd_ready;
  logic [31:0] data_rdata, ms_fwd_data;
  logic [4:0]  ms_fwd_dest;

  // 64-bit instance
  logic         ws_allowin64, ms_allowin64, es_valid64, ms_valid64;
  logic [105:0] es_bus64;
  logic [101:0] ws_bus64;
  logic         flush64, data_ok64, fwd_valid64, fwd_ready64;
  logic [63:0]  rdata64, fwd_data64;
  logic [4:0]   fwd_dest64;

  mem_stage_lsu #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ms_flush(ms_flush), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .ms_fwd_valid(ms_fwd_valid), .ms_fwd_dest(ms_fwd_dest),
    .ms_fwd_ready(ms_fwd_ready), .ms_fwd_data(ms_fwd_data));

  mem_stage_lsu #(.DATA_W(64)) dut64 (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin64), .ms_allowin(ms_allowin64),
    .es_to_ms_valid(es_valid64), .es_to_ms_bus(es_bus64),
    .ms_to_ws_valid(ms_valid64), .ms_to_ws_bus(ws_bus64),
    .ms_flush(flush64), .data_data_ok(data_ok64), .data_rdata(rdata64),
    .ms_fwd_valid(fwd_valid64), .ms_fwd_dest(fwd_dest64),
    .ms_fwd_ready(fwd_ready64), .ms_fwd_data(fwd_data64));

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference load extraction: shifts and masks on a 64-bit value.
  function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
    logic [63:0] m;
    m = (64'd1 << bits) - 64'd1;
    v = v & m;
    return v[bits-1] ? (v | ~m) : v;
  endfunction

  function automatic logic [63:0] ref_load(input int w, input logic [2:0] op,
                                           input logic [63:0] addr, input logic [63:0] d);
    int off;
    logic [63:0] r, keep;
    off  = int'(addr[2:0]) % (w / 8);
    keep = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    case (op)
      3'd1: r = sx(d >> (8 * off), 8);
      3'd2: r = sx(d >> (8 * (off & ~1)), 16);
      3'd3: r = (d >> (8 * off)) & 64'hFF;
      3'd4: r = (d >> (8 * (off & ~1))) & 64'hFFFF;
      3'd5: r = (w == 64) ? d : sx(d >> (8 * (off & ~3)), 32);
      default: r = sx(d >> (8 * (off & ~3)), 32);
    endcase
    return r & keep;
  endfunction

  function automatic logic [73:0] mk_bus(input logic [2:0] op, input logic rfm, input logic we,
                                         input logic [4:0] dest, input logic [31:0] alu,
                                         input logic [31:0] pc);
    return {op, rfm, we, dest, alu, pc};
  endfunction

  // Model of the 32-bit instance: one slot plus a count of flushed loads
  // whose responses are still on the bus.
  bit          m_has, m_loaded, m_load, m_we;
  logic [2:0]  m_op;
  logic [4:0]  m_dest;
  logic [31:0] m_alu, m_pc, m_rbuf;
  int          m_stale;

  task automatic tick();
    bit own_wait, delivered, ready, exp_valid, exp_allowin;
    logic [63:0] ext;
    logic [31:0] exp_res;
    @(negedge clk);
    if (reset) begin
      m_has = 0; m_stale = 0;
    end
    own_wait    = m_has && m_load && !m_loaded;
    delivered   = data_data_ok && (m_stale == 0) && own_wait;
    ready       = m_has && (m_loaded || delivered);
    exp_valid   = ready && !ms_flush;
    exp_allowin = !m_has || (ready && ws_allowin);
    ext         = ref_load(32, m_op, {32'd0, m_alu}, {32'd0, m_loaded ? m_rbuf : data_rdata});
    exp_res     = m_load ? ext[31:0] : m_alu;

    check("m_allowin", ms_allowin, exp_allowin);
    check("m_valid", ms_to_ws_valid, exp_valid);
    check("m_fwd_valid", ms_fwd_valid, m_has && m_we);
    check("m_fwd_ready", ms_fwd_ready, ready);
    if (exp_valid) check("m_bus", ms_to_ws_bus, {m_we, m_dest, exp_res, m_pc});
    if (m_has && m_we) check("m_fwd_dest", ms_fwd_dest, m_dest);
    if (ready) check("m_fwd_data", ms_fwd_data, exp_res);

    if (!reset) begin
      if (data_data_ok && m_stale > 0) m_stale--;
      if (ms_flush) begin
        if (own_wait && !delivered) m_stale++;
        m_has = 0;
      end else if (es_to_ms_valid && exp_allowin) begin
        {m_op, m_load, m_we, m_dest, m_alu, m_pc} = es_to_ms_bus;
        m_has = 1; m_loaded = !m_load;
      end else if (ready && ws_allowin) begin
        m_has = 0;
      end else if (delivered) begin
        m_loaded = 1; m_rbuf = data_rdata;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    int outstanding;
    outstanding    = m_stale + ((m_has && m_load && !m_loaded) ? 1 : 0);
    es_to_ms_valid = ($urandom_range(0, 9) < 6);
    es_to_ms_bus   = mk_bus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                            $urandom, $urandom);
    ws_allowin     = ($urandom_range(0, 9) < 7);
    ms_flush       = (m_stale < 3) && ($urandom_range(0, 99) < 8);
    data_data_ok   = (outstanding > 0) && ($urandom_range(0, 9) < 4);
    data_rdata     = $urandom;
  endtask

  initial begin
    logic [63:0] alu64, rd64, exp64;
    logic [2:0]  op64;
    es_to_ms_valid = 0; es_to_ms_bus = '0; ws_allowin = 1; ms_flush = 0;
    data_data_ok = 0; data_rdata = '0;
    es_valid64 = 0; es_bus64 = '0; ws_allowin64 = 1; flush64 = 0; data_ok64 = 0; rdata64 = '0;
    m_has = 0; m_loaded = 0; m_load = 0; m_we = 0; m_op = '0; m_dest = '0;
    m_alu = '0; m_pc = '0; m_rbuf = '0; m_stale = 0;

    #1 reset = 1;
    #2;
    check("rst_allowin", ms_allowin, 1);
    check("rst_valid", ms_to_ws_valid, 0);
    check("rst_bus", ms_to_ws_bus, 0);
    check("rst_fwd_valid", ms_fwd_valid, 0);
    check("rst_fwd_ready", ms_fwd_ready, 0);
    check("rst_cnt", dut.discard_cnt, 0);
    check("rst64_allowin", ms_allowin64, 1);
    check("rst64_out", {ms_valid64, ws_bus64, fwd_valid64, fwd_dest64, fwd_ready64, fwd_data64}, 0);
    tick();
    reset = 0;
    tick();

    // Non-load forwarded the cycle after acceptance.
    es_to_ms_valid = 1;
    es_to_ms_bus = mk_bus(3'd0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000);
    tick();
    es_to_ms_valid = 0;
    #2;
    check("nl_valid", ms_to_ws_valid, 1);
    check("nl_bus", ms_to_ws_bus, {1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000});
    tick();

    // ld.b / ld.bu at offset 3, data two cycles after acceptance.
    for (int k = 0; k < 2; k++) begin
      es_to_ms_valid = 1;
      es_to_ms_bus = mk_bus((k == 0) ? 3'd1 : 3'd3, 1'b1, 1'b1, 5'd7, 32'h0000_1003, 32'h1c00_0010);
      tick();
      es_to_ms_valid = 0;
      #2 check("ldb_wait_valid", ms_to_ws_valid, 0);
      tick();
      data_data_ok = 1; data_rdata = 32'h80FF_0000;
      #2;
      check("ldb_valid", ms_to_ws_valid, 1);
      check("ldb_result", ms_to_ws_bus[63:32], (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      tick();
      data_data_ok = 0;
    end

    // ld.h at offset 2 captured while writeback stalls, delivered once.
    es_to_ms_valid = 1;
    es_to_ms_bus = mk_bus(3'd2, 1'b1, 1'b1, 5'd8, 32'h0000_2002, 32'h1c00_0020);
    tick();
    es_to_ms_valid = 0; ws_allowin = 0; data_data_ok = 1; data_rdata = 32'h7FFF_1234;
    #2 check("ldh_result0", ms_to_ws_bus[63:32], 32'h0000_7FFF);
    tick();
    data_data_ok = 0;
    for (int k = 0; k < 2; k++) begin
      #2;
      check("ldh_hold_valid", ms_to_ws_valid, 1);
      check("ldh_hold_result", ms_to_ws_bus[63:32], 32'h0000_7FFF);
      tick();
    end
    ws_allowin = 1;
    #2 check("ldh_deliver", ms_to_ws_bus[63:32], 32'h0000_7FFF);
    tick();
    #2 check("ldh_once", ms_to_ws_valid, 0);

    // Flushed load leaves a stale response that the next load must skip.
    es_to_ms_valid = 1;
    es_to_ms_bus = mk_bus(3'd0, 1'b1, 1'b1, 5'd9, 32'h0000_3000, 32'h1c00_0030);
    tick();
    es_to_ms_valid = 0; ms_flush = 1;
    tick();
    ms_flush = 0;
    #2 check("fl_cnt1", dut.discard_cnt, 1);
    es_to_ms_valid = 1;
    es_to_ms_bus = mk_bus(3'd0, 1'b1, 1'b1, 5'd10, 32'h0000_4000, 32'h1c00_0040);
    data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
    tick();
    es_to_ms_valid = 0; data_data_ok = 0;
    #2;
    check("fl_cnt0", dut.discard_cnt, 0);
    check("fl_stale_dropped", ms_to_ws_valid, 0);
    tick();
    data_data_ok = 1; data_rdata = 32'h0000_0042;
    #2 check("fl_result", ms_to_ws_bus, {1'b1, 5'd10, 32'h0000_0042, 32'h1c00_0040});
    tick();
    data_data_ok = 0;

    // Reset asserted in WAIT with a pending stale response.
    es_to_ms_valid = 1;
    es_to_ms_bus = mk_bus(3'd0, 1'b1, 1'b1, 5'd11, 32'h0000_5000, 32'h1c00_0050);
    tick();
    es_to_ms_valid = 0; ms_flush = 1;
    tick();
    ms_flush = 0; es_to_ms_valid = 1;
    es_to_ms_bus = mk_bus(3'd0, 1'b1, 1'b1, 5'd12, 32'h0000_6000, 32'h1c00_0060);
    tick();
    es_to_ms_valid = 0;
    #2 check("rw_cnt1", dut.discard_cnt, 1);
    reset = 1;
    #1;
    check("rw_cnt0", dut.discard_cnt, 0);
    check("rw_outs", {ms_to_ws_valid, ms_to_ws_bus, ms_fwd_valid, ms_fwd_dest, ms_fwd_ready, ms_fwd_data}, 0);
    check("rw_allowin", ms_allowin, 1);
    tick();
    reset = 0;
    tick();

    // 64-bit datapath: ld.w at offset 4 and ld.d, then random loads.
    for (int k = 0; k < 2; k++) begin
      es_valid64 = 1;
      es_bus64 = {(k == 0) ? 3'd0 : 3'd5, 1'b1, 1'b1, 5'd3, 64'h0000_0000_0000_7004, 32'h1c00_0070};
      tick();
      es_valid64 = 0; data_ok64 = 1; rdata64 = 64'h8000_0000_0000_0001;
      #2;
      check("w64_valid", ms_valid64, 1);
      check("w64_result", ws_bus64[95:32], (k == 0) ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0001);
      tick();
      data_ok64 = 0;
    end
    for (int k = 0; k < 16; k++) begin
      op64  = 3'($urandom_range(0, 7));
      alu64 = {$urandom, $urandom};
      rd64  = {$urandom, $urandom};
      es_valid64 = 1;
      es_bus64 = {op64, 1'b1, 1'b1, 5'd4, alu64, 32'h1c00_0080};
      tick();
      es_valid64 = 0; data_ok64 = 1; rdata64 = rd64;
      exp64 = ref_load(64, op64, alu64, rd64);
      #2 check("r64_result", ws_bus64[95:32], exp64);
      tick();
      data_ok64 = 0;
    end

    // Randomized traffic on the 32-bit instance against the model.
    for (int c = 0; c < 4000; c++) begin
      randomize_inputs();
      tick();
    end
    es_to_ms_valid = 0; ms_flush = 0; data_data_ok = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
